// File: rtl/sensor_route_sched.sv
// sensor_route_sched: round-robin scheduler feeding the 1-to-8 sensor demux.
// Latency: 1 cycle from an accepted word to out_valid; words are spaced dwell+2 cycles apart.
// Backpressure: in_ready is asserted only while waiting for a word for the granted channel.
// Optional statistics (delivered_cnt, starved, stats_clr) are built when SENSOR_ROUTE_STATS_EN is defined.
module sensor_route_sched #(
  parameter int DATA_W  = 8,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         cfg_mask,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2:0]         address,
  output logic [DATA_W-1:0]  data_out,
  output logic               out_valid,
  output logic               busy
`ifdef SENSOR_ROUTE_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [15:0]        delivered_cnt,
  output logic [7:0]         starved
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEEK = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_ptr;
  logic [2:0]          w_ptr_nxt;
  logic [2:0]          r_address;
  logic [2:0]          w_address_nxt;
  logic [DATA_W-1:0]   r_data_out;
  logic [DATA_W-1:0]   w_data_out_nxt;
  logic                r_out_valid;
  logic                w_out_valid_nxt;
  logic                r_in_ready;
  logic                w_in_ready_nxt;
  logic [DWELL_W-1:0]  r_cnt;
  logic [DWELL_W-1:0]  w_cnt_nxt;

  logic                w_accept;
  logic [2:0]          w_pick;
  logic [DWELL_W-1:0]  w_dwell_eff;

  // Lowest enabled channel strictly after ptr, wrapping; k=8 lands back on ptr itself,
  // so a single enabled channel is reselected every pass.
  function automatic logic [2:0] f_pick(input logic [7:0] mask, input logic [2:0] ptr);
    logic [2:0] sel;
    logic [2:0] idx;
    sel = ptr;
    for (int k = 8; k >= 1; k--) begin
      idx = ptr + 3'(k);
      if (mask[idx]) sel = idx;
    end
    return sel;
  endfunction

  // in_ready is only ever high in WAIT, so this is the handshake for the granted channel.
  assign w_accept    = r_in_ready & in_valid;
  assign w_pick      = f_pick(cfg_mask, r_ptr);
  assign w_dwell_eff = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;

  assign in_ready  = r_in_ready;
  assign address   = r_address;
  assign data_out  = r_data_out;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != S_IDLE);

  // State and datapath registers; reset restarts the round-robin at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= 3'd7;
      r_address   <= 3'd0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_address   <= w_address_nxt;
      r_data_out  <= w_data_out_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  // Next-state and next-output logic; everything holds unless a state says otherwise.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_address_nxt   = r_address;
    w_data_out_nxt  = r_data_out;
    w_out_valid_nxt = r_out_valid;
    w_in_ready_nxt  = r_in_ready;
    w_cnt_nxt       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (cfg_mask != 8'd0) w_state_nxt = S_SEEK;
      end
      S_SEEK: begin
        if (cfg_mask == 8'd0) begin
          // Nothing eligible: park with the last address left on the bus.
          w_state_nxt = S_IDLE;
        end else begin
          w_address_nxt  = w_pick;
          w_ptr_nxt      = w_pick;
          w_in_ready_nxt = 1'b1;
          w_state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        // Mask changes here are deliberately not looked at until the next SEEK.
        if (w_accept) begin
          w_data_out_nxt  = in_data;
          w_cnt_nxt       = w_dwell_eff;
          w_out_valid_nxt = 1'b1;
          w_in_ready_nxt  = 1'b0;
          w_state_nxt     = S_HOLD;
        end
      end
      S_HOLD: begin
        // Dwell was latched at acceptance, so cfg_dwell edits only affect the next word.
        if (r_cnt <= DWELL_W'(1)) begin
          w_out_valid_nxt = 1'b0;
          w_data_out_nxt  = '0;
          w_state_nxt     = S_SEEK;
        end else begin
          w_cnt_nxt = r_cnt - DWELL_W'(1);
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_out_valid_nxt = 1'b0;
        w_in_ready_nxt  = 1'b0;
        w_data_out_nxt  = '0;
      end
    endcase
  end

`ifdef SENSOR_ROUTE_STATS_EN
  logic [15:0] r_delivered_cnt;
  logic [7:0]  r_starved;
  logic [7:0]  r_wait_cnt;
  logic        w_wait_idle;

  // A WAIT cycle that ends without a word counts towards starvation of the granted channel.
  assign w_wait_idle = (r_state == S_WAIT) && !w_accept;

  assign delivered_cnt = r_delivered_cnt;
  assign starved       = r_starved;

  // Saturating count of idle WAIT cycles, restarted on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 8'd0;
    end else if (r_state == S_SEEK) begin
      r_wait_cnt <= 8'd0;
    end else if (w_wait_idle && (r_wait_cnt != 8'hFF)) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // Delivery counter and sticky starvation flags; clear takes priority over update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_delivered_cnt <= 16'd0;
      r_starved       <= 8'd0;
    end else if (stats_clr) begin
      r_delivered_cnt <= 16'd0;
      r_starved       <= 8'd0;
    end else begin
      if (w_accept) r_delivered_cnt <= r_delivered_cnt + 16'd1;
      // The 256th consecutive idle cycle in WAIT flags the channel.
      if (w_wait_idle && (r_wait_cnt == 8'hFF)) r_starved[r_address] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sensor_route_sched.sv
// Directed bench for sensor_route_sched: walks grant order, dwell, masking, reset and stats.
module tb_sensor_route_sched;

  logic       clk;
  logic       rst_n;
  logic [7:0] cfg_mask;
  logic [3:0] cfg_dwell;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] address;
  logic [7:0] data_out;
  logic       out_valid;
  logic       busy;
`ifdef SENSOR_ROUTE_STATS_EN
  logic        stats_clr;
  logic [15:0] delivered_cnt;
  logic [7:0]  starved;
`endif

  int n_err;
  int n_checks;
  int cyc;

  sensor_route_sched #(.DATA_W(8), .DWELL_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_mask  (cfg_mask),
    .cfg_dwell (cfg_dwell),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .address   (address),
    .data_out  (data_out),
    .out_valid (out_valid),
    .busy      (busy)
`ifdef SENSOR_ROUTE_STATS_EN
    ,
    .stats_clr     (stats_clr),
    .delivered_cnt (delivered_cnt),
    .starved       (starved)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle=%0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [7:0] mask, input logic [3:0] dwell);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    cfg_mask = mask;
    cfg_dwell = dwell;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Offer one word and follow it through acceptance and its full hold window.
  task automatic serve(input logic [2:0] exp_addr, input logic [7:0] dat, input int dw_set,
                       input int dw_after, input int exp_n, output int acc_cyc);
    int k;
    int n;
    cfg_dwell = 4'(dw_set);
    in_data   = dat;
    in_valid  = 1'b1;
    acc_cyc   = -1;
    k = 0;
    while (in_ready !== 1'b1 && k < 300) begin
      tick();
      k++;
    end
    if (in_ready !== 1'b1) begin
      chk("ready_timeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    chk("grant_addr", {29'd0, address}, {29'd0, exp_addr});
    tick();
    acc_cyc = cyc;
    cfg_dwell = 4'(dw_after);
    chk("accept_valid", {31'd0, out_valid}, 32'd1);
    chk("accept_data", {24'd0, data_out}, {24'd0, dat});
    chk("ready_drop", {31'd0, in_ready}, 32'd0);
    n = 1;
    while (out_valid === 1'b1 && n < 40) begin
      tick();
      if (out_valid === 1'b1) n++;
    end
    chk("hold_cycles", n, exp_n);
    chk("data_zero_after_hold", {24'd0, data_out}, 32'd0);
    chk("addr_stable", {29'd0, address}, {29'd0, exp_addr});
  endtask

  initial begin
    int a_prev;
    int a_now;
    int k;
    n_err     = 0;
    n_checks  = 0;
    rst_n     = 1'b0;
    cfg_mask  = 8'h00;
    cfg_dwell = 4'd0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
`ifdef SENSOR_ROUTE_STATS_EN
    stats_clr = 1'b0;
`endif
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_addr", {29'd0, address}, 32'd0);
    chk("rst_data", {24'd0, data_out}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);

    // Full mask, dwell 2: grants 0..7 then wrap to 0, acceptances 4 cycles apart.
    cfg_mask  = 8'hFF;
    cfg_dwell = 4'd2;
    rst_n     = 1'b1;
    serve(3'd0, 8'hA0, 2, 2, 2, a_prev);
    for (int i = 1; i <= 8; i++) begin
      serve(3'(i), 8'(160 + i), 2, 2, 2, a_now);
      chk("spacing_dwell2", a_now - a_prev, 4);
      a_prev = a_now;
    end

    // Sparse mask, dwell 1: only 2,5,7 are eligible; spacing drops to 3.
    cfg_mask = 8'b1010_0100;
    serve(3'd2, 8'hB0, 1, 1, 1, a_prev);
    serve(3'd5, 8'hB1, 1, 1, 1, a_now);
    chk("spacing_dwell1", a_now - a_prev, 3);
    serve(3'd7, 8'hB2, 1, 1, 1, a_now);
    serve(3'd2, 8'hB3, 1, 1, 1, a_now);

    // Dwell 0 acts as 1; a dwell edit during HOLD applies to the next word only.
    serve(3'd5, 8'hC0, 0, 0, 1, a_now);
    serve(3'd7, 8'hC1, 3, 6, 3, a_now);
    serve(3'd2, 8'hC2, 6, 6, 6, a_now);

    // Empty mask parks in IDLE; a mask cleared during WAIT still lets the word through.
    do_reset(8'h00, 4'd2);
    repeat (3) tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
    cfg_mask = 8'h10;
    tick();
    chk("seek_busy", {31'd0, busy}, 32'd1);
    chk("seek_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("wait_in_ready", {31'd0, in_ready}, 32'd1);
    chk("wait_addr", {29'd0, address}, 32'd4);
    cfg_mask = 8'h00;
    tick();
    tick();
    chk("wait_hold_ready", {31'd0, in_ready}, 32'd1);
    chk("wait_hold_addr", {29'd0, address}, 32'd4);
    serve(3'd4, 8'h44, 2, 2, 2, a_now);
    chk("post_hold_seek_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("back_idle_busy", {31'd0, busy}, 32'd0);
    chk("back_idle_addr", {29'd0, address}, 32'd4);
    chk("back_idle_ready", {31'd0, in_ready}, 32'd0);

    // Reset asserted mid-HOLD on channel 3 clears outputs without a clock edge.
    do_reset(8'h08, 4'd5);
    in_data  = 8'hC3;
    in_valid = 1'b1;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk("ch3_ready", {31'd0, in_ready}, 32'd1);
    chk("ch3_addr", {29'd0, address}, 32'd3);
    tick();
    tick();
    chk("ch3_holding", {31'd0, out_valid}, 32'd1);
    chk("ch3_data", {24'd0, data_out}, 32'hC3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_data", {24'd0, data_out}, 32'd0);
    chk("async_in_ready", {31'd0, in_ready}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    tick();
    cfg_mask = 8'hFF;
    rst_n    = 1'b1;
    tick();
    chk("post_rst_no_word", {31'd0, out_valid}, 32'd0);
    serve(3'd0, 8'hD0, 1, 1, 1, a_now);

`ifdef SENSOR_ROUTE_STATS_EN
    // Statistics: ten deliveries, starvation on channel 1, clear beating an acceptance.
    do_reset(8'hFF, 4'd1);
    chk("stats_rst_cnt", {16'd0, delivered_cnt}, 32'd0);
    chk("stats_rst_starved", {24'd0, starved}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      serve(3'(i), 8'(i), 1, 1, 1, a_now);
    end
    chk("delivered_10", {16'd0, delivered_cnt}, 32'd10);
    cfg_mask = 8'h02;
    in_valid = 1'b0;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk("starve_addr", {29'd0, address}, 32'd1);
    repeat (255) tick();
    chk("starve_not_yet", {24'd0, starved}, 32'd0);
    tick();
    chk("starve_set", {24'd0, starved}, 32'h02);
    in_data   = 8'hEE;
    in_valid  = 1'b1;
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("clr_accepted", {31'd0, out_valid}, 32'd1);
    chk("clr_cnt", {16'd0, delivered_cnt}, 32'd0);
    chk("clr_starved", {24'd0, starved}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
